// File: rtl/exe_issue_queue_w15.sv
`default_nettype none
// ============================================================================
// Module      : exe_issue_queue_w15
// Description : Circular-FIFO issue queue feeding exe_unit_w15 over valid/ready,
//               with occupancy and sticky protocol-error outputs.
//               Optional same-cycle bypass when empty: define EXE_ISSUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_issue_queue_w15 #(
  parameter int ARG_BYTES  = 8,
  parameter int OPER_BYTES = 2,
  parameter int DEPTH      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rsn,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [OPER_BYTES-1:0]    i_oper,
  input  logic [ARG_BYTES-1:0]     i_argA,
  input  logic [ARG_BYTES-1:0]     i_argB,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [OPER_BYTES-1:0]    o_oper,
  output logic [ARG_BYTES-1:0]     o_argA,
  output logic [ARG_BYTES-1:0]     o_argB,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OPER_BYTES + 2 * ARG_BYTES;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic          r_stall;
  logic [EW-1:0] r_prev_payload;

  logic [EW-1:0] w_in_entry;
  logic [EW-1:0] w_head_entry;
  logic [EW-1:0] w_out_entry;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_byp_take;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_violation;

  assign w_in_entry   = {i_oper, i_argA, i_argB};
  assign w_head_entry = r_mem[r_rd_ptr];
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CW'(DEPTH));

  assign o_ready = !w_full;
  assign o_count = r_count;
  assign o_err   = r_err;

  // Empty queue drives zeros so head data never carries uninitialised storage.
`ifdef EXE_ISSUE_BYPASS_EN
  assign o_valid     = !w_empty || i_valid;
  assign w_out_entry = !w_empty ? w_head_entry : (i_valid ? w_in_entry : '0);
  assign w_byp_take  = w_empty && i_valid && i_ready;
`else
  assign o_valid     = !w_empty;
  assign w_out_entry = !w_empty ? w_head_entry : '0;
  assign w_byp_take  = 1'b0;
`endif

  assign o_oper = w_out_entry[EW-1 -: OPER_BYTES];
  assign o_argA = w_out_entry[2*ARG_BYTES-1 -: ARG_BYTES];
  assign o_argB = w_out_entry[ARG_BYTES-1:0];

  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;
  // A bypassed request never touches storage or the pointers.
  assign w_wr_en = w_push && !w_byp_take;
  assign w_rd_en = w_pop && !w_empty;

  // A held-off request must stay asserted with identical payload.
  assign w_violation = r_stall && (!i_valid || (w_in_entry != r_prev_payload));

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge i_clk or posedge i_rsn) begin
    if (i_rsn) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_err          <= 1'b0;
      r_stall        <= 1'b0;
      r_prev_payload <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count        <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
      r_stall        <= i_valid && !o_ready;
      r_prev_payload <= w_in_entry;
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_issue_queue_w15.sv
`default_nettype none
// Self-checking bench for exe_issue_queue_w15: vector table, scoreboard model
// and hand-written multi-cycle sequences (fill/drain, wrap, back-pressure, reset, bypass).
module tb_exe_issue_queue_w15;

`ifdef EXE_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk, rst;
  logic       in_valid, out_ready, out_valid, in_ready, err;
  logic [1:0] in_oper, out_oper;
  logic [7:0] in_a, in_b, out_a, out_b;
  logic [2:0] count;

  exe_issue_queue_w15 #(.ARG_BYTES(8), .OPER_BYTES(2), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rsn(rst), .i_valid(in_valid), .o_ready(out_ready),
    .i_oper(in_oper), .i_argA(in_a), .i_argB(in_b),
    .o_valid(out_valid), .i_ready(in_ready),
    .o_oper(out_oper), .o_argA(out_a), .o_argB(out_b),
    .o_count(count), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } entry_t;

  typedef struct {
    bit         v;
    bit         r;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         exp_count;
  } vec_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  entry_t sb[$];
  int     m_cnt;
  bit     m_err, m_prev_stall, accepted;
  entry_t m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit r, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    in_valid = v; in_ready = r; in_oper = op; in_a = a; in_b = b;
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt = 0; m_err = 0; m_prev_stall = 0; m_prev = '0;
  endtask

  // Compare outputs at the falling edge, then advance the model across the next rising edge.
  task automatic tick();
    bit     exp_valid, exp_ready, push, byp_take;
    entry_t cur, head;
    @(negedge clk);
    cur       = '{in_oper, in_a, in_b};
    exp_valid = (m_cnt != 0) || (BYP && in_valid);
    exp_ready = (m_cnt != DEPTH);
    chk("o_valid", 32'(out_valid), 32'(exp_valid));
    chk("o_ready", 32'(out_ready), 32'(exp_ready));
    chk("o_count", 32'(count), 32'(m_cnt));
    chk("o_err", 32'(err), 32'(m_err));
    push     = in_valid && exp_ready;
    byp_take = BYP && (m_cnt == 0) && in_valid && in_ready;
    if (exp_valid && in_ready) begin
      head = (m_cnt != 0) ? sb.pop_front() : cur;
      chk("head", 32'({out_oper, out_a, out_b}), 32'(head));
    end
    if (push && !byp_take) sb.push_back(cur);
    m_cnt = sb.size();
    if (m_prev_stall && (!in_valid || cur != m_prev)) m_err = 1;
    m_prev_stall = in_valid && !exp_ready;
    m_prev       = cur;
    accepted     = push;
    @(posedge clk);
    #1;
  endtask

  vec_t   vecs[17];
  entry_t items[10];
  int     k, budget;

  initial begin
    vecs[0]  = '{1, 0, 2'd0, 8'h11, 8'h22, 0};
    vecs[1]  = '{1, 0, 2'd1, 8'h33, 8'h44, 1};
    vecs[2]  = '{1, 0, 2'd2, 8'h55, 8'h66, 2};
    vecs[3]  = '{1, 0, 2'd3, 8'h77, 8'h88, 3};
    vecs[4]  = '{0, 0, 2'd0, 8'h00, 8'h00, 4};
    vecs[5]  = '{0, 1, 2'd0, 8'h00, 8'h00, 4};
    vecs[6]  = '{0, 1, 2'd0, 8'h00, 8'h00, 3};
    vecs[7]  = '{0, 1, 2'd0, 8'h00, 8'h00, 2};
    vecs[8]  = '{0, 1, 2'd0, 8'h00, 8'h00, 1};
    vecs[9]  = '{0, 0, 2'd0, 8'h00, 8'h00, 0};
    vecs[10] = '{1, 0, 2'd1, 8'hA1, 8'hB1, 0};
    vecs[11] = '{1, 0, 2'd2, 8'hA2, 8'hB2, 1};
    vecs[12] = '{1, 1, 2'd3, 8'hA3, 8'hB3, 2};
    vecs[13] = '{0, 0, 2'd0, 8'h00, 8'h00, 2};
    vecs[14] = '{0, 1, 2'd0, 8'h00, 8'h00, 2};
    vecs[15] = '{0, 1, 2'd0, 8'h00, 8'h00, 1};
    vecs[16] = '{0, 0, 2'd0, 8'h00, 8'h00, 0};

    // Reset state
    rst = 1'b1;
    drive(0, 0, 2'd0, 8'h00, 8'h00);
    model_reset();
    #1;
    chk("reset o_valid", 32'(out_valid), 32'd0);
    chk("reset o_ready", 32'(out_ready), 32'd1);
    chk("reset o_count", 32'(count), 32'd0);
    chk("reset o_err", 32'(err), 32'd0);
    chk("reset head", 32'({out_oper, out_a, out_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill/drain ordering and simultaneous push+pop at count 2
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].v, vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b);
      #2;
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      tick();
    end

    // Wrap-around: 10 items with i_ready toggling
    for (int i = 0; i < 10; i++) items[i] = entry_t'($urandom);
    k = 0; budget = 0;
    while (k < 10 && budget < 100) begin
      drive(1, budget[0], items[k].op, items[k].a, items[k].b);
      tick();
      if (accepted) k++;
      budget++;
    end
    chk("wrap all pushed", 32'(k), 32'd10);
    budget = 0;
    while (m_cnt != 0 && budget < 20) begin
      drive(0, 1, 2'd0, 8'h00, 8'h00);
      tick();
      budget++;
    end
    chk("wrap drained", 32'(sb.size()), 32'd0);
    chk("wrap o_count", 32'(count), 32'd0);

    // Full back-pressure with a well-behaved upstream
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2'(i), 8'(8'hC0 + i), 8'(8'hD0 + i));
      tick();
    end
    chk("full o_ready", 32'(out_ready), 32'd0);
    drive(1, 0, 2'd2, 8'hEE, 8'hFF);
    for (int i = 0; i < 5; i++) tick();
    in_ready = 1'b1;
    budget = 0;
    accepted = 0;
    while (!accepted && budget < 10) begin
      tick();
      budget++;
    end
    chk("held req accepted", 32'(accepted), 32'd1);
    budget = 0;
    while (m_cnt != 0 && budget < 20) begin
      drive(0, 1, 2'd0, 8'h00, 8'h00);
      tick();
      budget++;
    end
    chk("bp no err", 32'(err), 32'd0);
    chk("bp drained", 32'(count), 32'd0);

    // Withdrawn request while full sets the sticky error
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2'(i), 8'(8'h40 + i), 8'(8'h50 + i));
      tick();
    end
    drive(1, 0, 2'd1, 8'h99, 8'h98);
    tick();
    drive(0, 0, 2'd0, 8'h00, 8'h00);
    tick();
    chk("err set", 32'(err), 32'd1);
    tick();
    tick();
    chk("err sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-stream at count 3
    drive(0, 1, 2'd0, 8'h00, 8'h00);
    tick();
    drive(0, 0, 2'd0, 8'h00, 8'h00);
    chk("pre-reset count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst o_valid", 32'(out_valid), 32'd0);
    chk("async rst o_count", 32'(count), 32'd0);
    chk("async rst o_ready", 32'(out_ready), 32'd1);
    chk("async rst o_err", 32'(err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bypass / minimum latency
    drive(1, 1, 2'd2, 8'h0F, 8'hF0);
    #2;
    chk("byp o_valid same cycle", 32'(out_valid), 32'(BYP));
    chk("byp o_count", 32'(count), 32'd0);
    if (BYP) chk("byp head", 32'({out_oper, out_a, out_b}), 32'({2'd2, 8'h0F, 8'hF0}));
    tick();
    drive(0, 0, 2'd0, 8'h00, 8'h00);
    #2;
    chk("lat o_valid next", 32'(out_valid), 32'(!BYP));
    chk("lat o_count next", 32'(count), 32'(!BYP));
    tick();
    drive(0, 1, 2'd0, 8'h00, 8'h00);
    tick();
    tick();
    chk("final count", 32'(count), 32'd0);
    chk("final sb empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
